// File: rtl/gf_inv_share_feeder.sv
// Front end of the 3-share masked GF(2^8) inverter. It splits each accepted byte into Boolean shares,
// feeds fresh LFSR randomness to the inverter and tracks which inverter outputs carry real data.
module gf_inv_share_feeder #(
    parameter logic [31:0] SEED = 32'hACE1_5EED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        seed_load,
    input  logic [31:0] seed,
    output logic [7:0]  sh1,
    output logic [7:0]  sh2,
    output logic [7:0]  sh3,
    output logic [3:0]  r1,
    output logic [3:0]  r2,
    output logic [3:0]  r3,
    output logic [3:0]  r4,
    output logic        sh_valid,
    output logic        out_valid
);

    logic [31:0] r_lfsr;
    logic [7:0]  r_sh1;
    logic [7:0]  r_sh2;
    logic [7:0]  r_sh3;
    logic [2:0]  r_vpipe;

    logic [31:0] w_lfsr_next;
    logic [31:0] w_seed_safe;
    logic        w_accept;
    logic [7:0]  w_data;
    logic [7:0]  w_m1;
    logic [7:0]  w_m2;

    // x^32+x^22+x^2+x+1, advanced 32 steps so every output bit is fresh each cycle
    function automatic logic [31:0] lfsr_adv32(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 32; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    assign in_ready    = ~seed_load;
    assign w_accept    = in_valid & ~seed_load;
    assign w_data      = w_accept ? in_byte : 8'h00;
    assign w_m1        = r_lfsr[7:0];
    assign w_m2        = r_lfsr[15:8];
    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign w_seed_safe = (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
    assign w_lfsr_next = seed_load ? w_seed_safe : lfsr_adv32(r_lfsr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr  <= SEED;
            r_sh1   <= 8'h00;
            r_sh2   <= 8'h00;
            r_sh3   <= 8'h00;
            r_vpipe <= 3'b000;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_sh1   <= w_data ^ w_m1 ^ w_m2;
            r_sh2   <= w_m1;
            r_sh3   <= w_m2;
            r_vpipe <= {r_vpipe[1:0], w_accept};
        end
    end

    assign sh1       = r_sh1;
    assign sh2       = r_sh2;
    assign sh3       = r_sh3;
    assign r1        = r_lfsr[19:16];
    assign r2        = r_lfsr[23:20];
    assign r3        = r_lfsr[27:24];
    assign r4        = r_lfsr[31:28];
    assign sh_valid  = r_vpipe[0];
    // Two more stages line up with the inverter's internal registers
    assign out_valid = r_vpipe[2];

endmodule

// File: tb/tb_gf_inv_share_feeder.sv
// Bench for gf_inv_share_feeder: a cycle-level reference model checked on every falling edge,
// plus hand-computed literal values at reset, first accept, seed loads and reset mid-stream.
module tb_gf_inv_share_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        seed_load;
    logic [31:0] seed;
    logic [7:0]  sh1, sh2, sh3;
    logic [3:0]  r1, r2, r3, r4;
    logic        sh_valid, out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gf_inv_share_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .seed_load(seed_load),
        .seed     (seed),
        .sh1      (sh1),
        .sh2      (sh2),
        .sh3      (sh3),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .r4       (r4),
        .sh_valid (sh_valid),
        .out_valid(out_valid)
    );

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LFSR: one polynomial step at a time, 32 per clock
    function automatic logic [31:0] ref_adv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 32; k++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    // Model state: S, masks taken on the last edge, expected share XOR, accept history
    logic [31:0] m_s     = 32'hACE1_5EED;
    logic [7:0]  m_lo    = 8'h00;
    logic [7:0]  m_hi    = 8'h00;
    logic [7:0]  m_d     = 8'h00;
    logic [2:0]  m_hist  = 3'b000;
    bit          m_fresh = 1'b0;
    bit          m_acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s = 32'hACE1_5EED; m_lo = 8'h00; m_hi = 8'h00; m_d = 8'h00;
            m_hist = 3'b000; m_fresh = 1'b0;
        end else begin
            m_acc   = in_valid && !seed_load;
            m_d     = m_acc ? in_byte : 8'h00;
            m_lo    = m_s[7:0];
            m_hi    = m_s[15:8];
            m_hist  = {m_hist[1:0], m_acc};
            m_fresh = !seed_load;
            if (seed_load) m_s = (seed == 32'h0) ? 32'h1 : seed;
            else           m_s = ref_adv(m_s);
        end
    end

    logic [15:0] last_r = 16'h0;

    always @(negedge clk) begin
        expect_eq("r_bus", {r4, r3, r2, r1}, m_s[31:16]);
        expect_eq("sh2_mask", sh2, m_lo);
        expect_eq("sh3_mask", sh3, m_hi);
        expect_eq("share_xor", sh1 ^ sh2 ^ sh3, m_d);
        expect_eq("sh_valid", sh_valid, m_hist[0]);
        expect_eq("out_valid", out_valid, m_hist[2]);
        expect_eq("in_ready", in_ready, !seed_load);
        if (m_fresh) begin
            n_chk++;
            if ({r4, r3, r2, r1} === last_r) begin
                n_fail++;
                $display("FAIL r_fresh: got %h repeated, required a change at %0t", last_r, $time);
            end
        end
        last_r = {r4, r3, r2, r1};
    end

    task automatic drive(input bit v, input logic [7:0] b, input bit sl, input logic [31:0] sd);
        @(negedge clk);
        #2;
        in_valid = v; in_byte = b; seed_load = sl; seed = sd;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_byte = 8'h53; seed_load = 1'b0; seed = 32'h0;
        #1 rst = 1'b0;
        #1;
        expect_eq("reset_r", {r4, r3, r2, r1}, 16'hACE1);
        expect_eq("reset_shares", {sh1, sh2, sh3}, 24'h0);
        expect_eq("reset_out_valid", out_valid, 1'b0);
        #1 rst = 1'b1;

        after_edge();
        expect_eq("first_sh1", sh1, 8'hE0);
        expect_eq("first_sh2", sh2, 8'hED);
        expect_eq("first_sh3", sh3, 8'h5E);
        expect_eq("first_sh_valid", sh_valid, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 32'h0);
        after_edge();
        expect_eq("first_out_valid_early", out_valid, 1'b0);
        after_edge();
        expect_eq("first_out_valid", out_valid, 1'b1);

        drive(1'b0, 8'h00, 1'b1, 32'h0000_0001);
        after_edge();
        expect_eq("seed1_r", {r4, r3, r2, r1}, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 32'h0);
        after_edge();
        expect_eq("step_from_1_hi", {r4, r3, r2, r1}, 16'hB6DB);
        after_edge();
        expect_eq("step_from_1_lo", {sh3, sh2}, 16'h68A3);
        expect_eq("step_from_1_sh1", sh1, 8'hCB);

        for (int i = 0; i < 256; i++) drive(i % 3 == 0, 8'(i * 7), 1'b0, 32'h0);

        drive(1'b1, 8'hAA, 1'b1, 32'h0);
        #1;
        expect_eq("zero_seed_in_ready", in_ready, 1'b0);
        after_edge();
        expect_eq("zero_seed_r", {r4, r3, r2, r1}, 16'h0000);
        expect_eq("zero_seed_sh_valid", sh_valid, 1'b0);
        expect_eq("zero_seed_xor", sh1 ^ sh2 ^ sh3, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 32'h0);
        after_edge();
        expect_eq("zero_seed_step", {r4, r3, r2, r1}, 16'hB6DB);

        for (int i = 0; i < 100; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 32'h0);

        drive(1'b1, 8'h11, 1'b0, 32'h0);
        drive(1'b1, 8'h22, 1'b0, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        expect_eq("midrst_r", {r4, r3, r2, r1}, 16'hACE1);
        expect_eq("midrst_shares", {sh1, sh2, sh3}, 24'h0);
        expect_eq("midrst_valids", {sh_valid, out_valid}, 2'b00);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b0, 32'h0);

        drive(1'b1, 8'h5A, 1'b0, 32'h0);
        after_edge();
        expect_eq("post_rst_sh_valid", sh_valid, 1'b1);
        after_edge();
        expect_eq("post_rst_out_valid_early", out_valid, 1'b0);
        after_edge();
        expect_eq("post_rst_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_inv_share_feeder.md
# gf_inv_share_feeder

Front-end stage for the 3-share masked GF(2^8) inverter (`GF_INV_8_shared`). It accepts one unmasked byte per cycle over a valid/ready handshake and splits it into three Boolean shares using two fresh 8-bit masks. Every cycle it also supplies the inverter's four 4-bit fresh-randomness inputs from an internal 32-bit LFSR. A 3-deep valid pipeline flags the cycle in which the inverter's output shares correspond to an accepted byte.

## Interface
- `SEED`, default 32'hACE1_5EED: LFSR value after reset; must be nonzero.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_byte` is presented.
- `in_byte` input 8: unmasked byte.
- `in_ready` output 1: the byte is accepted on an edge where `in_valid & in_ready`.
- `seed_load` input 1: load `seed` into the LFSR.
- `seed` input 32: new LFSR value.
- `sh1`, `sh2`, `sh3` output 8 each: registered shares, wired to the inverter share inputs.
- `r1`, `r2`, `r3`, `r4` output 4 each: fresh randomness, wired to the inverter r inputs.
- `sh_valid` output 1: the current `sh1..sh3` encode an accepted byte.
- `out_valid` output 1: the inverter's current output shares correspond to an accepted byte.

## Operation
- **LFSR state S (32 bits).**
  - One step: `fb = S[31]^S[21]^S[1]^S[0]`, then `S = {S[30:0], fb}`. This is polynomial x^32+x^22+x^2+x+1, which is maximal length.
  - Each non-reset edge without `seed_load`: S advances by exactly 32 unrolled steps.
  - Edge with `seed_load=1`: S <= `seed` unstepped. If `seed==0`, S <= 32'h0000_0001 instead.
  - S is never zero.
- **Randomness outputs.** Driven directly from the S register, fresh every cycle:
  - `r1=S[19:16]`, `r2=S[23:20]`, `r3=S[27:24]`, `r4=S[31:28]`.
- **Masks.** Taken from the current S: `m1=S[7:0]`, `m2=S[15:8]`.
- **Share registers, updated every edge:**
  - `sh2 <= m1`, `sh3 <= m2`.
  - `sh1 <= d ^ m1 ^ m2`.
  - `d = in_byte` if the byte is accepted, else 8'h00. Idle cycles therefore carry fresh shares of zero; shares never hold stale values.
- **Handshake.**
  - `in_ready = ~seed_load`, combinational.
  - The byte is not accepted on a `seed_load` cycle. Masks on that edge come from the pre-load S.
- **Valid pipeline.**
  - `v0 <= accept`, `v1 <= v0`, `v2 <= v1`.
  - `sh_valid = v0`, `out_valid = v2`.
  - The pipeline advances every cycle. There is no stall, because the inverter has none.
- **Share invariant.** `sh1^sh2^sh3` equals the accepted byte when `sh_valid=1`, and 8'h00 otherwise.

## Timing
- **Reset (`rst=0`, asynchronous):**
  - S=`SEED`; `sh1..sh3`=8'h00; `v0..v2`=0.
  - `r1..r4` therefore show `SEED` nibbles immediately.
  - `in_ready` depends only on `seed_load`.
- **Latency.**
  - Byte accepted at edge k gives `sh_valid=1` in the cycle after edge k.
  - `out_valid=1` follows in the cycle after edge k+2, matching the inverter's two internal register stages.
- **Throughput.** One byte per cycle, back to back, with no bubbles.
- **Fresh randomness.** `r1..r4` change on every edge (except the `seed_load` edge, where they take the seed nibbles). The inverter consumes r1/r2 at its first stage and r3/r4 at its second stage from different S values.
- **Reset mid-operation.** In-flight valids are dropped (v0..v2 cleared). The first post-reset accept restarts at latency 3.
- **Simultaneous `seed_load` and `in_valid`.** Load wins, byte not accepted, `v0 <= 0`.

## Test plan
- **Reset value:** SEED default, release reset, observe before the first edge -> `r1=4'h1`, `r2=4'hE`, `r3=4'hC`, `r4=4'hA`; `sh1..sh3=0`; `out_valid=0`.
- **First accept:** first edge with `in_valid=1`, `in_byte=8'h53` -> `sh2=8'hED`, `sh3=8'h5E`, `sh1=8'hE0`, `sh_valid=1`. `out_valid=1` two cycles later.
- **LFSR step:** `seed_load` with `seed=32'h0000_0001` -> S=1. Next edge -> S equals a reference model of 32 steps. A 256-edge run matches the model and S is never 0.
- **Zero-seed guard:** `seed_load` with `seed=0` and `in_valid=1` simultaneously -> S=32'h1, `in_ready=0`, `sh_valid=0`, shares XOR to 8'h00.
- **Streaming with downstream model:** 100 random back-to-back bytes through the feeder plus inverter -> `out_valid` high exactly 3 cycles after each accept. The XOR of the output shares equals the reference inversion each time, and `r1..r4` never repeat over consecutive cycles.
- **Mid-stream reset:** assert `rst=0` for one cycle mid-stream after 2 accepts -> `v0..v2`, shares and S return to reset values asynchronously, and no `out_valid` pulse occurs for the dropped bytes.
